// File: rtl/sequencer_pkg.sv
// Shared encodings and helpers for the sixteen-step sequencer and its LFSR.
package sequencer_pkg;

  typedef enum logic [1:0] {
    DIR_FWD  = 2'b00,
    DIR_REV  = 2'b01,
    DIR_PING = 2'b10,
    DIR_RAND = 2'b11
  } dir_e;

  typedef enum logic {
    PP_UP   = 1'b0,
    PP_DOWN = 1'b1
  } pp_dir_e;

  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;
  // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register (bits 15,13,12,10).
  localparam logic [15:0] LFSR_TAP_MASK     = 16'hB400;

  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAP_MASK)};
  endfunction

  function automatic logic [3:0] fill_below_msb(input logic [3:0] v);
    return v | (v >> 1) | (v >> 2) | (v >> 3);
  endfunction

endpackage

// File: rtl/sixteen_step_sequencer_lfsr16.sv
// 16-bit Fibonacci LFSR stepping once per enabled cycle.
module lfsr16
  import sequencer_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = DEFAULT_LFSR_SEED
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  output logic [15:0] o_state
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = state_q;
    if (i_enable) state_d = lfsr16_next(state_q);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state_q <= LFSR_SEED;
    else            state_q <= state_d;
  end

  assign o_state = state_q;

endmodule

// File: rtl/sixteen_step_sequencer.sv
// Tempo-driven 16-step index generator with gate and step strobe for a 16x1 CV mux.
module sixteen_step_sequencer
  import sequencer_pkg::*;
#(
  parameter int unsigned TEMPO_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_LFSR_SEED
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_run,
  input  logic [TEMPO_WIDTH-1:0] i_tempo,
  input  logic [3:0]             i_length,
  input  logic [1:0]             i_direction,
  input  logic                   i_step_req,
  input  logic                   i_restart,
  output logic [3:0]             o_select,
  output logic                   o_gate,
  output logic                   o_step_strobe
);

  logic [3:0]             sel_q, sel_d;
  logic                   gate_q, gate_d;
  logic                   strobe_q, strobe_d;
  logic [TEMPO_WIDTH-1:0] count_q, count_d;
  pp_dir_e                pp_q, pp_d;

  logic [15:0] lfsr_q;
  logic        lfsr_en;
  logic        advance;
  logic [3:0]  step_adv;
  pp_dir_e     pp_adv;
  logic [3:0]  rnd_bits;
  logic [3:0]  rnd_v;
  logic        go_up;
  dir_e        dir;

  lfsr16 #(
    .LFSR_SEED (LFSR_SEED)
  ) u_lfsr (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_enable  (lfsr_en),
    .o_state   (lfsr_q)
  );

  // Next step candidate; random mode uses the LFSR value produced by this advance.
  always_comb begin
    dir      = dir_e'(i_direction);
    step_adv = sel_q;
    pp_adv   = pp_q;
    go_up    = 1'b0;
    rnd_bits = 4'(lfsr16_next(lfsr_q));
    rnd_v    = rnd_bits & fill_below_msb(i_length);
    case (dir)
      DIR_FWD: step_adv = (sel_q >= i_length) ? '0 : sel_q + 4'd1;
      DIR_REV: step_adv = (sel_q == '0 || sel_q > i_length) ? i_length : sel_q - 4'd1;
      DIR_PING: begin
        if (i_length == '0) begin
          step_adv = '0;
          pp_adv   = PP_UP;
        end else if (sel_q > i_length) begin
          step_adv = i_length;
          pp_adv   = PP_DOWN;
        end else begin
          // An endpoint always turns the walk around, whatever the stored flag says.
          go_up    = (pp_q == PP_UP && sel_q != i_length) || sel_q == '0;
          step_adv = go_up ? sel_q + 4'd1 : sel_q - 4'd1;
          if (step_adv == i_length) pp_adv = PP_DOWN;
          else if (step_adv == '0)  pp_adv = PP_UP;
          else                      pp_adv = go_up ? PP_UP : PP_DOWN;
        end
      end
      DIR_RAND: step_adv = (rnd_v <= i_length) ? rnd_v : rnd_v - (i_length + 4'd1);
      default:  step_adv = sel_q;
    endcase
  end

  always_comb begin
    sel_d    = sel_q;
    pp_d     = pp_q;
    count_d  = count_q;
    gate_d   = 1'b0;
    strobe_d = 1'b0;
    advance  = 1'b0;
    if (i_restart) begin
      sel_d    = '0;
      count_d  = '0;
      pp_d     = PP_UP;
      strobe_d = 1'b1;
      gate_d   = i_run;
    end else if (i_run) begin
      // >= keeps a shortened tempo from running the count all the way round.
      if (count_q >= i_tempo) begin
        count_d = '0;
        advance = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      gate_d = (count_d <= (i_tempo >> 1));
    end else begin
      count_d = '0;
      if (i_step_req) begin
        advance = 1'b1;
        gate_d  = 1'b1;
      end
    end
    if (advance) begin
      sel_d    = step_adv;
      pp_d     = pp_adv;
      strobe_d = 1'b1;
    end
    lfsr_en = advance && (dir == DIR_RAND);
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      sel_q    <= '0;
      gate_q   <= 1'b0;
      strobe_q <= 1'b0;
      count_q  <= '0;
      pp_q     <= PP_UP;
    end else begin
      sel_q    <= sel_d;
      gate_q   <= gate_d;
      strobe_q <= strobe_d;
      count_q  <= count_d;
      pp_q     <= pp_d;
    end
  end

  assign o_select      = sel_q;
  assign o_gate        = gate_q;
  assign o_step_strobe = strobe_q;

endmodule

// File: tb/tb_sixteen_step_sequencer.sv
// Randomized self-checking bench for sixteen_step_sequencer against a step-level model.
module tb_sixteen_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [15:0] tempo;
  logic [3:0]  length;
  logic [1:0]  direction;
  logic        step_req;
  logic        restart;
  logic [3:0]  sel;
  logic        gate;
  logic        strobe;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: current step, length, mode, tempo, ping-pong phase, LFSR.
  int          m_sel, m_len, m_dir, m_tempo, m_phase;
  logic [15:0] m_lfsr;
  int          seen[$];

  sixteen_step_sequencer #(
    .TEMPO_WIDTH (16),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .i_clock       (clk),
    .i_reset_n     (reset_n),
    .i_run         (run),
    .i_tempo       (tempo),
    .i_length      (length),
    .i_direction   (direction),
    .i_step_req    (step_req),
    .i_restart     (restart),
    .o_select      (sel),
    .o_gate        (gate),
    .o_step_strobe (strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic model_advance();
    int msb, mask, v;
    case (m_dir)
      0: m_sel = (m_sel > m_len) ? 0 : (m_sel + 1) % (m_len + 1);
      1: m_sel = (m_sel == 0 || m_sel > m_len) ? m_len : m_sel - 1;
      2: begin
        if (m_len == 0) m_sel = 0;
        else begin
          m_phase = (m_phase + 1) % (2 * m_len);
          m_sel   = (m_phase <= m_len) ? m_phase : 2 * m_len - m_phase;
        end
      end
      default: begin
        m_lfsr = lfsr_model(m_lfsr);
        msb = -1;
        for (int i = 0; i < 4; i++) if (m_len[i]) msb = i;
        mask = (1 << (msb + 1)) - 1;
        v = int'(m_lfsr[3:0]) & mask;
        m_sel = (v <= m_len) ? v : v - (m_len + 1);
      end
    endcase
  endtask

  task automatic set_mode(input int d, input int len, input int tp);
    direction = 2'(d);
    length    = 4'(len);
    tempo     = 16'(tp);
    m_dir = d; m_len = len; m_tempo = tp;
  endtask

  // Restart while running lands on phase 0 of step 0 with gate high.
  task automatic start_auto(input int d, input int len, input int tp);
    set_mode(d, len, tp);
    run = 1'b1;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_sel = 0;
    m_phase = 0;
    seen.delete();
  endtask

  task automatic run_steps(input int n);
    for (int s = 0; s < n; s++) begin
      for (int ph = 0; ph <= m_tempo; ph++) begin
        check_eq("auto_sel", sel, m_sel);
        check_eq("auto_strobe", strobe, (ph == 0) ? 1 : 0);
        check_eq("auto_gate", gate, (ph <= m_tempo / 2) ? 1 : 0);
        if (ph == 0) begin
          seen.push_back(int'(sel));
          if (m_dir == 3) check_eq("rand_in_range", (sel <= 4'(m_len)) ? 1 : 0, 1);
        end
        tick();
      end
      model_advance();
    end
  endtask

  task automatic step_pulse(input string tag);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    model_advance();
    check_eq({tag, "_sel"}, sel, m_sel);
    check_eq({tag, "_gate"}, gate, 1);
    check_eq({tag, "_strobe"}, strobe, 1);
    tick();
    check_eq({tag, "_gate_off"}, gate, 0);
    check_eq({tag, "_strobe_off"}, strobe, 0);
  endtask

  task automatic manual_restart();
    run = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    m_sel = 0;
    m_phase = 0;
    check_eq("man_restart_sel", sel, 0);
    check_eq("man_restart_gate", gate, 0);
  endtask

  int exp_fwd[17];
  int exp_pp[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
  int exp_rev[7] = '{0, 4, 3, 2, 1, 0, 4};

  initial begin
    reset_n = 1'b0; run = 1'b0; step_req = 1'b0; restart = 1'b0;
    tempo = 16'd3; length = 4'd15; direction = 2'd0;
    m_lfsr = 16'hACE1;
    tick();
    tick();
    check_eq("reset_sel", sel, 0);
    check_eq("reset_gate", gate, 0);
    check_eq("reset_strobe", strobe, 0);
    reset_n = 1'b1;

    // Forward from a cold start: first advance tempo+1 edges after run rises.
    set_mode(0, 15, 3);
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("cold_no_strobe", strobe, 0);
    end
    tick();
    check_eq("cold_first_sel", sel, 1);
    check_eq("cold_first_strobe", strobe, 1);

    start_auto(0, 15, 3);
    run_steps(17);
    for (int i = 0; i < 17; i++) exp_fwd[i] = i % 16;
    for (int i = 0; i < 17; i++) check_eq("fwd_seq", seen[i], exp_fwd[i]);

    start_auto(2, 3, 1);
    run_steps(8);
    for (int i = 0; i < 8; i++) check_eq("ping_seq", seen[i], exp_pp[i]);

    start_auto(1, 4, $urandom_range(0, 3));
    run_steps(7);
    for (int i = 0; i < 7; i++) check_eq("rev_seq", seen[i], exp_rev[i]);

    // Deasserting run mid-step drops gate, holds select.
    start_auto(0, 15, 5);
    tick();
    tick();
    run = 1'b0;
    tick();
    check_eq("stop_gate", gate, 0);
    check_eq("stop_sel", sel, 0);
    check_eq("stop_strobe", strobe, 0);

    // Manual stepping.
    set_mode(0, 15, 3);
    manual_restart();
    for (int i = 0; i < 3; i++) step_pulse("man_fwd");
    check_eq("man_fwd_at3", sel, 3);
    restart = 1'b1;
    step_req = 1'b1;
    tick();
    restart = 1'b0;
    step_req = 1'b0;
    check_eq("restart_beats_step", sel, 0);
    check_eq("restart_strobe", strobe, 1);
    m_sel = 0;

    // Step request ignored while running.
    run = 1'b1;
    tempo = 16'd20;
    restart = 1'b1;
    tick();
    restart = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    check_eq("step_ignored_run", sel, 0);
    run = 1'b0;
    tick();

    // Length shortened below the current step.
    set_mode(0, 15, 3);
    manual_restart();
    for (int i = 0; i < 10; i++) step_pulse("man_to10");
    length = 4'd5; m_len = 5;
    step_pulse("fwd_shrink");
    check_eq("fwd_shrink_zero", sel, 0);

    set_mode(1, 15, 3);
    manual_restart();
    for (int i = 0; i < 6; i++) step_pulse("rev_to10");
    check_eq("rev_at10", sel, 10);
    length = 4'd5; m_len = 5;
    step_pulse("rev_shrink");
    check_eq("rev_shrink_len", sel, 5);

    // Reset mid-run overrides everything, then the divider restarts from 0.
    start_auto(0, 15, 3);
    run_steps(3);
    tick();
    reset_n = 1'b0;
    restart = 1'b1;
    step_req = 1'b1;
    tick();
    check_eq("midrst_sel", sel, 0);
    check_eq("midrst_gate", gate, 0);
    check_eq("midrst_strobe", strobe, 0);
    reset_n = 1'b1;
    restart = 1'b0;
    step_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_no_strobe", strobe, 0);
    end
    tick();
    check_eq("post_rst_first_strobe", strobe, 1);
    check_eq("post_rst_first_sel", sel, 1);

    // Random mode from the reset seed.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_lfsr = 16'hACE1;
    start_auto(3, 5, $urandom_range(0, 2));
    run_steps(64);

    // Randomized mode/length/tempo mix; LFSR state carries through.
    for (int k = 0; k < 8; k++) begin
      start_auto($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 4));
      run_steps(2 * m_len + 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sixteen_step_sequencer.md
# sixteen_step_sequencer

Clocked 16-step sequencer that generates the 4-bit step select driving `sixteen_bit_16x1_mux`, plus a per-step gate and step strobe for the envelope/VCA path. Sits directly upstream of the mux: `o_select` connects to the mux `i_select`, so the mux output walks through the 16 programmed CV words. Step rate comes from an internal tempo divider; direction, length, run/stop, manual step and restart are user controls.

## Interface
- `TEMPO_WIDTH`, 16, width of tempo divider and `i_tempo`
- `LFSR_SEED`, 16'hACE1, random-mode LFSR reset value (must be non-zero)

- `i_clock`  in  1  system clock
- `i_reset_n`  in  1  reset; synchronous, active-low
- `i_run`  in  1  level; 1 = auto-advance on tempo
- `i_tempo`  in  TEMPO_WIDTH  clock cycles per step minus 1
- `i_length`  in  4  last step index; sequence length = `i_length`+1
- `i_direction`  in  2  00 forward, 01 reverse, 10 ping-pong, 11 random
- `i_step_req`  in  1  one-cycle manual advance pulse; honoured only while `i_run`=0
- `i_restart`  in  1  one-cycle pulse; jump to step 0
- `o_select`  out  4  current step index, to mux `i_select`
- `o_gate`  out  1  registered gate for current step
- `o_step_strobe`  out  1  one-cycle pulse, high in first cycle a new step is presented

## Operation
- All outputs registered. Reset (`i_reset_n`=0 at an edge): `o_select`=0, `o_gate`=0, `o_step_strobe`=0, divider count=0, ping-pong direction=up, LFSR=`LFSR_SEED`.
- Divider: while `i_run`=1, count increments each cycle 0..`i_tempo`. At count==`i_tempo` the count returns to 0 and an advance occurs. While `i_run`=0, count is held at 0.
- Advance computes next step from `o_select`, `i_length` and `i_direction`:
  - Forward: +1; if `o_select`>=`i_length`, go to 0.
  - Reverse: −1; if `o_select`==0 or `o_select`>`i_length`, go to `i_length`.
  - Ping-pong: endpoints not repeated (length 3: 0,1,2,3,2,1,0,1…). Flip direction flag on reaching 0 or `i_length`. If `o_select`>`i_length`, go to `i_length` with flag=down. Length 0: stays at 0.
  - Random: LFSR steps once per advance; polynomial x^16+x^14+x^13+x^11+1, Fibonacci, shift left, feedback into bit 0. Let v = lfsr[3:0] & m, where m = `i_length` with all bits below its MSB set. Next step = v if v<=`i_length`, else v−(`i_length`+1). Repeats of the same step are allowed.
- Every advance, including one yielding an unchanged index, pulses `o_step_strobe`.
- `o_gate`, auto mode: next gate = `i_run` & (next count <= `i_tempo`>>1). `i_tempo`=0 gives a constant-high gate while running.
- Manual: `i_step_req`=1 with `i_run`=0 performs one advance and asserts `o_gate` and `o_step_strobe` for exactly one cycle. It is ignored while `i_run`=1.
- Priority, highest first: reset, `i_restart`, tempo/manual advance. `i_restart` sets `o_select`=0, count=0, flag=up and pulses strobe. Gate follows the auto rule with count 0. The LFSR is not reseeded.
- Control inputs are sampled every cycle. Changes take effect at the next advance, with no glitch on `o_select`.

## Timing
- With `i_run` held high from cycle 0: first advance at the edge ending cycle `i_tempo`. Period = `i_tempo`+1 cycles.
- `o_select` and `o_step_strobe` change on the same edge. Strobe is high for the first cycle of the new step only.
- Manual/restart latency: one edge from pulse to new `o_select`.
- Deasserting `i_run` mid-step: count→0 and `o_gate`→0 on the next edge. `o_select` is held.
- Reset mid-sequence: reset values on the next edge, regardless of other inputs.

## Structure
- Shared package `sequencer_pkg`: direction encodings (`DIR_FWD`/`DIR_REV`/`DIR_PING`/`DIR_RAND`), default LFSR seed, tap mask.
- One sub-module, `lfsr16`: clock, sync active-low reset, enable, seed parameter, 16-bit state out. The next-step logic and divider stay in the top.

## Test plan
- Forward, `i_tempo`=3, `i_length`=15, run: `o_select` 0→1→…→15→0, one step per 4 cycles; strobe once per step; gate high 2 of 4 cycles.
- Ping-pong, `i_length`=3: sequence 0,1,2,3,2,1,0,1. Reverse, `i_length`=4 from 0: 4,3,2,1,0,4.
- Forward at `o_select`=10, set `i_length`=5: next advance gives 0. Reverse with same change: next advance gives 5.
- `i_run`=0, three `i_step_req` pulses: `o_select` 0→1→2→3, each with one-cycle gate+strobe. `i_restart`+`i_step_req` in the same cycle: `o_select`=0.
- Random, `i_length`=5, 64 steps: every `o_select`<=5 and the sequence matches the bench LFSR model from seed 16'hACE1.
- Reset asserted mid-run with `i_run`=1: next cycle `o_select`=0, `o_gate`=0, strobe=0. After release, first advance comes `i_tempo`+1 cycles later.
